alu_result_display: RTL

Output-side companion to the 4-bit ALU: captures the ALU's result, flags and op code on a strobe and presents them on a 4-digit, time-multiplexed, active-low seven-segment display plus three flag LEDs. For add/sub ops it decodes the two's-complement result into sign + magnitude; for all other ops it shows raw hex. It sits between the ALU outputs and the board's display pins.

---
 rtl/alu_result_display_if.sv | 18 +
 rtl/alu_result_display.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/alu_result_display_if.sv
// Capture bus from the 4-bit ALU into the result display: strobe, op code,
// result nibble and the three ALU flags.
interface alu_result_display_if;
  logic       in_valid;
  logic [2:0] in_op;
  logic [3:0] in_result;
  logic       in_carry;
  logic       in_zero;
  logic       in_overflow;

  modport master (
    output in_valid, in_op, in_result, in_carry, in_zero, in_overflow
  );

  modport slave (
    input  in_valid, in_op, in_result, in_carry, in_zero, in_overflow
  );
endinterface

// File: rtl/alu_result_display.sv
// Captures ALU result/flags/op and drives a 4-digit multiplexed active-low
// seven-segment display plus flag LEDs. Optional overflow blink: ALU_DISP_BLINK_EN.
module alu_result_display #(
  parameter int unsigned SCAN_DIV     = 1000,
  parameter int unsigned BLINK_ROUNDS = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  alu_result_display_if.slave  alu,
  output logic [7:0]           seg_out,
  output logic [3:0]           digit_sel,
  output logic [2:0]           flag_led
);

  if (SCAN_DIV < 2 || BLINK_ROUNDS < 1) begin : g_param_check
    $error("alu_result_display: SCAN_DIV must be >= 2 and BLINK_ROUNDS >= 1");
  end

  localparam int unsigned        DIV_W    = $clog2(SCAN_DIV);
  localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(SCAN_DIV - 1);

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_DASH  = 8'hBF;
  localparam logic [7:0] SEG_E     = 8'h86;
  localparam logic [7:0] DP_ON     = 8'h7F;

  typedef enum logic [1:0] {
    DIG_VALUE = 2'd0,
    DIG_SIGN  = 2'd1,
    DIG_OVF   = 2'd2,
    DIG_OP    = 2'd3
  } digit_t;

  function automatic logic [7:0] hex_glyph(input logic [3:0] v);
    case (v)
      4'h0: return 8'hC0;
      4'h1: return 8'hF9;
      4'h2: return 8'hA4;
      4'h3: return 8'hB0;
      4'h4: return 8'h99;
      4'h5: return 8'h92;
      4'h6: return 8'h82;
      4'h7: return 8'hF8;
      4'h8: return 8'h80;
      4'h9: return 8'h90;
      4'hA: return 8'h88;
      4'hB: return 8'h83;
      4'hC: return 8'hC6;
      4'hD: return 8'hA1;
      4'hE: return 8'h86;
      default: return 8'h8E;
    endcase
  endfunction

  // Captured ALU state
  logic [2:0] op_q;
  logic [3:0] result_q;
  logic       carry_q;
  logic       zero_q;
  logic       ovf_q;

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q     <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else if (alu.in_valid) begin
      op_q     <= alu.in_op;
      result_q <= alu.in_result;
      carry_q  <= alu.in_carry;
      zero_q   <= alu.in_zero;
      ovf_q    <= alu.in_overflow;
    end
  end

  // Add/sub results are two's complement; 4'b1000 maps to magnitude 8.
  logic       is_arith;
  logic       neg;
  logic [3:0] value;

  assign is_arith = (op_q == 3'd0) || (op_q == 3'd1);
  assign neg      = is_arith && result_q[3];
  assign value    = neg ? (~result_q + 4'd1) : result_q;

  // Scan divider and digit index
  logic [DIV_W-1:0] div_q;
  digit_t           idx_q;
  logic             div_wrap;

  assign div_wrap = (div_q == DIV_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q <= '0;
      idx_q <= DIG_VALUE;
    end else if (div_wrap) begin
      div_q <= '0;
      idx_q <= digit_t'(idx_q + 2'd1);
    end else begin
      div_q <= div_q + DIV_W'(1);
    end
  end

  logic dark;

`ifdef ALU_DISP_BLINK_EN
  localparam int unsigned      RND_W    = $clog2(BLINK_ROUNDS + 1);
  localparam logic [RND_W-1:0] RND_LAST = RND_W'(BLINK_ROUNDS - 1);

  logic [RND_W-1:0] rounds_q;
  logic             phase_on_q;
  logic             round_end;

  assign round_end = div_wrap && (idx_q == DIG_OP);

  always_ff @(posedge clk) begin
    if (rst) begin
      rounds_q   <= '0;
      phase_on_q <= 1'b1;
    end else if (round_end) begin
      if (rounds_q == RND_LAST) begin
        rounds_q   <= '0;
        phase_on_q <= ~phase_on_q;
      end else begin
        rounds_q <= rounds_q + RND_W'(1);
      end
    end
  end

  // Only an overflowed result blinks; flag LEDs stay steady.
  assign dark = ovf_q && !phase_on_q;
`else
  assign dark = 1'b0;
`endif

  // Glyph for the digit currently selected
  logic [7:0] glyph;
  logic [3:0] sel_onehot;

  always_comb begin
    // NOTE: default first so no path through the case can infer a latch.
    glyph = SEG_BLANK;
    unique case (idx_q)
      DIG_VALUE: glyph = hex_glyph(value);
      DIG_SIGN:  glyph = neg   ? SEG_DASH : SEG_BLANK;
      DIG_OVF:   glyph = ovf_q ? SEG_E    : SEG_BLANK;
      DIG_OP:    glyph = hex_glyph({1'b0, op_q}) & DP_ON;
    endcase
  end

  assign sel_onehot = ~(4'b0001 << idx_q);

  // Segments and digit enable come from the same index in the same register
  // stage, so the pins never show one digit's glyph on another's enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_out   <= SEG_BLANK;
      digit_sel <= 4'b1111;
      flag_led  <= 3'b000;
    end else begin
      seg_out   <= glyph;
      digit_sel <= dark ? 4'b1111 : sel_onehot;
      flag_led  <= {ovf_q, carry_q, zero_q};
    end
  end

endmodule
